// File: rtl/cbus_sram_responder_if.sv
// CBus request/response bundle between an initiator (master) and a memory responder (slave).
// req_burst: 1 = INCR (address steps by 8 per beat), 0 = FIXED.
interface cbus_sram_responder_if;
  logic        req_valid;
  logic        req_is_write;
  logic [2:0]  req_size;
  logic [63:0] req_addr;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic [3:0]  req_len;
  logic        req_burst;

  logic        resp_ready;
  logic        resp_last;
  logic [63:0] resp_data;

  modport master (
    output req_valid, req_is_write, req_size, req_addr, req_strobe, req_data, req_len, req_burst,
    input  resp_ready, resp_last, resp_data
  );

  modport slave (
    input  req_valid, req_is_write, req_size, req_addr, req_strobe, req_data, req_len, req_burst,
    output resp_ready, resp_last, resp_data
  );
endinterface

// File: rtl/cbus_sram_responder.sv
// CBus responder backed by a 64-bit word array: one request at a time, single or burst beats
// after a fixed access latency, with optional idle gap cycles between beats.
module cbus_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned BEAT_GAP    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  cbus_sram_responder_if.slave  cbus,
  output logic                  err
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [63:0] TopAddr  = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd8;
  // WAIT spans LATENCY+1 cycles so the first beat lands LATENCY+1 edges after capture.
  localparam logic [3:0]  WaitLoad = 4'(LATENCY);
  localparam logic [2:0]  GapLoad  = (BEAT_GAP > 0) ? 3'(BEAT_GAP - 1) : 3'd0;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWait = 3'd1;
  localparam logic [2:0] StBeat = 3'd2;
  localparam logic [2:0] StGap  = 3'd3;
  localparam logic [2:0] StTurn = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  gap_cnt_q, gap_cnt_d;
  logic [3:0]  beats_left_q, beats_left_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic        is_write_q, is_write_d;
  logic        incr_q, incr_d;

  logic [63:0] mem [DEPTH_WORDS];

  logic [63:0]   offset;
  logic [IdxW-1:0] idx;
  logic          in_range;
  logic          beat;
  logic          mem_we;
  logic [63:0]   rdata;
  logic          unused_bits;

  // Per-beat range check on the registered address; the index wraps modulo the depth.
  always_comb begin
    offset   = cur_addr_q - BASE_ADDR;
    idx      = offset[3 +: IdxW];
    in_range = (cur_addr_q >= BASE_ADDR) && (cur_addr_q < TopAddr);
    beat     = (state_q == StBeat);
    mem_we   = beat && is_write_q && in_range;
    rdata    = mem[idx];
  end

  assign unused_bits = ^{cbus.req_size, offset[63:3+IdxW], offset[2:0]};

  always_comb begin
    cbus.resp_ready = beat;
    cbus.resp_last  = beat && (beats_left_q == 4'd0);
    cbus.resp_data  = (beat && in_range && !is_write_q) ? rdata : 64'd0;
    err             = beat && !in_range;
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    beats_left_d = beats_left_q;
    cur_addr_d   = cur_addr_q;
    is_write_d   = is_write_q;
    incr_d       = incr_q;
    case (state_q)
      StIdle: begin
        if (cbus.req_valid) begin
          is_write_d   = cbus.req_is_write;
          incr_d       = cbus.req_burst;
          cur_addr_d   = cbus.req_addr;
          beats_left_d = cbus.req_len;
          wait_cnt_d   = WaitLoad;
          state_d      = StWait;
        end
      end
      StWait: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = StBeat;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StBeat: begin
        if (beats_left_q == 4'd0) begin
          state_d = StTurn;
        end else begin
          beats_left_d = beats_left_q - 4'd1;
          if (incr_q) begin
            cur_addr_d = cur_addr_q + 64'd8;
          end
          if (BEAT_GAP > 0) begin
            gap_cnt_d = GapLoad;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == 3'd0) begin
          state_d = StBeat;
        end else begin
          gap_cnt_d = gap_cnt_q - 3'd1;
        end
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wait_cnt_q   <= 4'd0;
      gap_cnt_q    <= 3'd0;
      beats_left_q <= 4'd0;
      cur_addr_q   <= 64'd0;
      is_write_q   <= 1'b0;
      incr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      beats_left_q <= beats_left_d;
      cur_addr_q   <= cur_addr_d;
      is_write_q   <= is_write_d;
      incr_q       <= incr_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (cbus.req_strobe[k]) begin
          mem[idx][8*k +: 8] <= cbus.req_data[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Scoreboard bench for cbus_sram_responder: a byte-level model predicts every beat, and the
// driver checks first-beat latency and beat spacing.
module tb_cbus_sram_responder;

  localparam int unsigned Depth = 4096;
  localparam logic [63:0] Base  = 64'h8000_0000;
  localparam logic [63:0] Top   = Base + 64'(Depth) * 64'd8;
  localparam int unsigned Lat   = 2;
  localparam int unsigned Gap   = 2;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  logic err;
  int   cyc;
  int   n_checks;
  int   n_errors;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] model_mem [int];
  logic [63:0] wdata [16];

  cbus_sram_responder_if cbus ();

  cbus_sram_responder #(
    .DEPTH_WORDS (Depth),
    .BASE_ADDR   (Base),
    .LATENCY     (Lat),
    .BEAT_GAP    (Gap)
  ) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .cbus  (cbus.slave),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ready beat pops one expectation; idle cycles must show zero outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cbus.resp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("beat_data", cbus.resp_data, mon_e.data);
          check_eq("beat_last", 64'(cbus.resp_last), 64'(mon_e.last));
          check_eq("beat_err", 64'(err), 64'(mon_e.err));
        end
      end else begin
        check_eq("idle_data", cbus.resp_data, 64'd0);
        check_eq("idle_last", 64'(cbus.resp_last), 64'd0);
        check_eq("idle_err", 64'(err), 64'd0);
      end
    end
  end

  task automatic push_exp(input bit wr, input logic [63:0] addr, input int len, input bit incr,
                          input logic [7:0] strb);
    logic [63:0] a;
    bit          inr;
    int          idx;
    exp_t        e;
    for (int i = 0; i <= len; i++) begin
      a      = incr ? addr + 64'(8 * i) : addr;
      inr    = (a >= Base) && (a < Top);
      idx    = int'(((a - Base) >> 3) & 64'(Depth - 1));
      e.last = (i == len);
      e.err  = !inr;
      e.data = 64'd0;
      if (wr) begin
        if (inr) begin
          for (int k = 0; k < 8; k++) begin
            if (strb[k]) model_mem[idx][8*k +: 8] = wdata[i][8*k +: 8];
          end
        end
      end else if (inr) begin
        e.data = model_mem[idx];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_req(input bit wr, input logic [63:0] addr, input int len, input bit incr,
                           input logic [7:0] strb);
    cbus.req_valid    = 1'b1;
    cbus.req_is_write = wr;
    cbus.req_size     = 3'd3;
    cbus.req_addr     = addr;
    cbus.req_len      = 4'(len);
    cbus.req_burst    = incr;
    cbus.req_strobe   = strb;
    cbus.req_data     = wdata[0];
  endtask

  // Called at posedge+1; cap_edges is how many edges remain until the DUT captures.
  task automatic run_txn(input bit wr, input logic [63:0] addr, input int len, input bit incr,
                         input logic [7:0] strb, input bit keep_valid, input int cap_edges);
    int prev;
    int waited;
    drive_req(wr, addr, len, incr, strb);
    push_exp(wr, addr, len, incr, strb);
    repeat (cap_edges) @(posedge clk);
    #1;
    prev = cyc;
    for (int i = 0; i <= len; i++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!cbus.resp_ready && waited < 64);
      if (!cbus.resp_ready) begin
        check_eq("beat_timeout", 64'd0, 64'd1);
        cbus.req_valid = 1'b0;
        return;
      end
      if (i == 0) check_eq("first_latency", 64'(cyc - prev), 64'(Lat + 1));
      else        check_eq("beat_spacing", 64'(cyc - prev), 64'(Gap + 1));
      prev = cyc;
      @(posedge clk);
      #1;
      if (wr && i < len) cbus.req_data = wdata[i + 1];
    end
    if (!keep_valid) begin
      cbus.req_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int waited;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    cbus.req_valid = 1'b0;
    cbus.req_is_write = 1'b0;
    cbus.req_size = 3'd0;
    cbus.req_addr = 64'd0;
    cbus.req_strobe = 8'd0;
    cbus.req_data = 64'd0;
    cbus.req_len = 4'd0;
    cbus.req_burst = 1'b0;
    #3;
    check_eq("rst_ready", 64'(cbus.resp_ready), 64'd0);
    check_eq("rst_last", 64'(cbus.resp_last), 64'd0);
    check_eq("rst_data", cbus.resp_data, 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload then single read.
    wdata[0] = 64'hDEAD_BEEF_0123_4567;
    run_txn(1'b1, Base, 0, 1'b1, 8'hFF, 1'b0, 1);
    run_txn(1'b0, Base, 0, 1'b1, 8'hFF, 1'b0, 1);

    // INCR write and read-back.
    for (int i = 0; i < 4; i++) wdata[i] = 64'(i + 1);
    run_txn(1'b1, Base + 64'h10, 3, 1'b1, 8'hFF, 1'b0, 1);
    run_txn(1'b0, Base + 64'h10, 3, 1'b1, 8'hFF, 1'b0, 1);

    // FIXED write: last beat wins.
    wdata[0] = 64'hAAAA_0000_1111_2222;
    wdata[1] = 64'hBBBB_3333_4444_5555;
    run_txn(1'b1, Base + 64'h20, 1, 1'b0, 8'hFF, 1'b0, 1);
    run_txn(1'b0, Base + 64'h20, 0, 1'b1, 8'hFF, 1'b0, 1);

    // Partial strobe onto a cleared word.
    wdata[0] = 64'd0;
    run_txn(1'b1, Base, 0, 1'b1, 8'hFF, 1'b0, 1);
    wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_txn(1'b1, Base, 0, 1'b1, 8'h0F, 1'b0, 1);
    run_txn(1'b0, Base, 0, 1'b1, 8'hFF, 1'b0, 1);

    // Out of range: below base, write above top must not alias word 0.
    run_txn(1'b0, 64'h7FFF_FFF8, 0, 1'b1, 8'hFF, 1'b0, 1);
    wdata[0] = 64'h1234_5678_9ABC_DEF0;
    run_txn(1'b1, Top, 0, 1'b1, 8'hFF, 1'b0, 1);
    run_txn(1'b0, Base, 0, 1'b1, 8'hFF, 1'b0, 1);

    // Top word, then INCR read crossing the end of range.
    wdata[0] = 64'hC0FF_EE00_CAFE_F00D;
    run_txn(1'b1, Top - 64'd8, 0, 1'b1, 8'hFF, 1'b0, 1);
    run_txn(1'b0, Top - 64'd8, 1, 1'b1, 8'hFF, 1'b0, 1);

    // Unaligned address indexes the containing word.
    run_txn(1'b0, Base + 64'h13, 0, 1'b1, 8'hFF, 1'b0, 1);

    // Reset during beat 2 of a 4-beat read.
    drive_req(1'b0, Base + 64'h10, 3, 1'b1, 8'hFF);
    push_exp(1'b0, Base + 64'h10, 3, 1'b1, 8'hFF);
    seen   = 0;
    waited = 0;
    while (seen < 2 && waited < 200) begin
      @(negedge clk);
      waited++;
      if (cbus.resp_ready) seen++;
    end
    check_eq("rst_burst_reached", 64'(seen), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_ready", 64'(cbus.resp_ready), 64'd0);
    check_eq("async_rst_last", 64'(cbus.resp_last), 64'd0);
    check_eq("async_rst_data", cbus.resp_data, 64'd0);
    check_eq("async_rst_err", 64'(err), 64'd0);
    exp_q.delete();
    cbus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn(1'b0, Base + 64'h10, 0, 1'b1, 8'hFF, 1'b0, 1);

    // Back-to-back with valid held high: second capture only after TURN.
    run_txn(1'b0, Base + 64'h10, 1, 1'b1, 8'hFF, 1'b1, 1);
    run_txn(1'b0, Base + 64'h20, 0, 1'b1, 8'hFF, 1'b0, 2);

    repeat (5) @(posedge clk);
    #1;
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
